// File: rtl/led_pattern_gen.sv
// led_pattern_gen: drives LED_NUM LEDs with a run-time-selectable pattern
// (rotate left, rotate right, ping-pong, blink-all). The step period is
// STEP_CYCLES << SPEED_i clock cycles.
// Optional build macro LED_PWM_EN adds a DUTY_i input. That input gates the
// LED outputs with a free-running 4-bit PWM counter.
module led_pattern_gen #(
  parameter int CLK_FREQ = 300_000_000,
  parameter int LED_NUM  = 8,
  parameter int STEP_MS  = 250
) (
  input  logic               CLK_i,
  input  logic               RSTn_i,
  input  logic               ENABLE_i,
  input  logic [1:0]         MODE_i,
  input  logic [1:0]         SPEED_i,
`ifdef LED_PWM_EN
  input  logic [3:0]         DUTY_i,
`endif
  output logic [LED_NUM-1:0] LED_o,
  output logic               STEP_o
);

  localparam int STEP_CYCLES = CLK_FREQ / 1000 * STEP_MS;
  localparam int CNT_W       = $clog2((STEP_CYCLES << 3) + 1);

  typedef enum logic [1:0] {
    MODE_ROL   = 2'b00,
    MODE_ROR   = 2'b01,
    MODE_PING  = 2'b10,
    MODE_BLINK = 2'b11
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [CNT_W-1:0]   r_cnt;
  mode_t              r_mode;
  dir_t               r_dir;
  logic [LED_NUM-1:0] r_pattern;
  logic               r_step;

  logic [CNT_W-1:0]   w_cnt_next;
  dir_t               w_dir_next;
  logic [LED_NUM-1:0] w_pattern_next;
  logic               w_step_next;
  logic [CNT_W-1:0]   w_term;
  logic               w_tick;
  logic               w_mode_chg;
  mode_t              w_mode_in;

  // Starting pattern for each mode. It is also used to recover from an
  // all-zero pattern in the one-hot modes.
  function automatic logic [LED_NUM-1:0] initPattern(input mode_t m);
    logic [LED_NUM-1:0] p;
    case (m)
      MODE_ROR:   p = {1'b1, {(LED_NUM-1){1'b0}}};
      MODE_BLINK: p = '1;
      default:    p = {{(LED_NUM-1){1'b0}}, 1'b1};
    endcase
    return p;
  endfunction

  assign w_mode_in  = mode_t'(MODE_i);
  assign w_mode_chg = (w_mode_in != r_mode);
  // SPEED_i feeds the terminal value directly. Because the compare below is
  // >= rather than ==, lowering the speed mid-period ticks at once instead of
  // wrapping the counter.
  assign w_term     = (CNT_W'(STEP_CYCLES) << SPEED_i) - CNT_W'(1);
  assign w_tick     = (r_cnt >= w_term);

  // Next-state logic. A mode change takes priority over a tick. After that,
  // the prescaler advances, or a step is taken when the prescaler reaches
  // its terminal count.
  always_comb begin
    w_cnt_next     = r_cnt;
    w_dir_next     = r_dir;
    w_pattern_next = r_pattern;
    w_step_next    = 1'b0;
    if (w_mode_chg) begin
      w_pattern_next = initPattern(w_mode_in);
      w_cnt_next     = '0;
      w_dir_next     = DIR_UP;
    end else if (ENABLE_i) begin
      if (w_tick) begin
        w_cnt_next  = '0;
        w_step_next = 1'b1;
        if ((r_mode != MODE_BLINK) && (r_pattern == '0)) begin
          w_pattern_next = initPattern(r_mode);
          w_dir_next     = DIR_UP;
        end else begin
          case (r_mode)
            MODE_ROL: w_pattern_next = {r_pattern[LED_NUM-2:0], r_pattern[LED_NUM-1]};
            MODE_ROR: w_pattern_next = {r_pattern[0], r_pattern[LED_NUM-1:1]};
            MODE_PING: begin
              if (r_dir == DIR_UP) begin
                w_pattern_next = r_pattern << 1;
                if (w_pattern_next[LED_NUM-1]) w_dir_next = DIR_DOWN;
              end else begin
                w_pattern_next = r_pattern >> 1;
                if (w_pattern_next[0]) w_dir_next = DIR_UP;
              end
            end
            default:  w_pattern_next = ~r_pattern;
          endcase
        end
      end else begin
        w_cnt_next = r_cnt + CNT_W'(1);
      end
    end
  end

  // State registers. The mode input is sampled every cycle so that the next
  // edge can detect a change.
  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      r_cnt     <= '0;
      r_mode    <= MODE_ROL;
      r_dir     <= DIR_UP;
      r_pattern <= {{(LED_NUM-1){1'b0}}, 1'b1};
      r_step    <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_next;
      r_mode    <= w_mode_in;
      r_dir     <= w_dir_next;
      r_pattern <= w_pattern_next;
      r_step    <= w_step_next;
    end
  end

  assign STEP_o = r_step;

`ifdef LED_PWM_EN
  logic [3:0]         r_pwm_cnt;
  logic [LED_NUM-1:0] r_led;

  // The free-running PWM counter gates the next pattern into the registered
  // LED drive. The pattern state and STEP_o are not affected by this gating.
  always_ff @(posedge CLK_i or negedge RSTn_i) begin
    if (!RSTn_i) begin
      r_pwm_cnt <= '0;
      r_led     <= {{(LED_NUM-1){1'b0}}, 1'b1};
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 4'd1;
      r_led     <= w_pattern_next & {LED_NUM{(r_pwm_cnt < DUTY_i)}};
    end
  end

  assign LED_o = r_led;
`else
  assign LED_o = r_pattern;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: directed self-checking bench for led_pattern_gen.
// It uses CLK_FREQ=4000, STEP_MS=1 and LED_NUM=8, so the base step period is
// 4 cycles.
module tb_led_pattern_gen;

  logic       clk;
  logic       rstN;
  logic       enable;
  logic [1:0] mode;
  logic [1:0] speed;
  logic [7:0] led;
  logic       step;
`ifdef LED_PWM_EN
  logic [3:0] duty = 4'd15;
`endif

  int testCount = 0;
  int failCount = 0;

  led_pattern_gen #(
    .CLK_FREQ(4000),
    .LED_NUM (8),
    .STEP_MS (1)
  ) dut (
    .CLK_i   (clk),
    .RSTn_i  (rstN),
    .ENABLE_i(enable),
    .MODE_i  (mode),
    .SPEED_i (speed),
`ifdef LED_PWM_EN
    .DUTY_i  (duty),
`endif
    .LED_o   (led),
    .STEP_o  (step)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic en, input logic [1:0] m, input logic [1:0] s);
    enable = en;
    mode   = m;
    speed  = s;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Directed sequence that walks through every scenario in order.
  initial begin
    logic [7:0] expLed;
    logic       up;
    int         ones;
    int         msbs;

    rstN = 1'b0;
    applyStimulus(1'b0, 2'b00, 2'b00);
    #23;
    checkOutput("reset_led", {24'd0, led}, 32'h01);
    checkOutput("reset_step", {31'd0, step}, 32'd0);
    rstN = 1'b1;
    stepCycles(1);

    // Rotate left, one step every 4 cycles.
    applyStimulus(1'b1, 2'b00, 2'b00);
    expLed = 8'h01;
    for (int i = 0; i < 8; i++) begin
      stepCycles(3);
      checkOutput("rol_hold", {24'd0, led}, {24'd0, expLed});
      checkOutput("rol_hold_step", {31'd0, step}, 32'd0);
      expLed = {expLed[6:0], expLed[7]};
      stepCycles(1);
      checkOutput("rol_led", {24'd0, led}, {24'd0, expLed});
      checkOutput("rol_step", {31'd0, step}, 32'd1);
    end

    // Ping-pong: reload to 01, then a 14-step period with each end lit once.
    applyStimulus(1'b1, 2'b10, 2'b00);
    stepCycles(1);
    checkOutput("ping_reload", {24'd0, led}, 32'h01);
    checkOutput("ping_reload_step", {31'd0, step}, 32'd0);
    expLed = 8'h01;
    up     = 1'b1;
    ones   = 0;
    msbs   = 0;
    for (int i = 1; i <= 15; i++) begin
      if (up) begin
        expLed = expLed << 1;
        if (expLed[7]) up = 1'b0;
      end else begin
        expLed = expLed >> 1;
        if (expLed[0]) up = 1'b1;
      end
      stepCycles(4);
      checkOutput("ping_led", {24'd0, led}, {24'd0, expLed});
      if (i <= 14) begin
        if (led == 8'h01) ones++;
        if (led == 8'h80) msbs++;
      end
    end
    checkOutput("ping_end0_once", ones, 32'd1);
    checkOutput("ping_end7_once", msbs, 32'd1);

    // Blink-all at speed x4, then a speed drop at count 10.
    applyStimulus(1'b1, 2'b11, 2'b10);
    stepCycles(1);
    checkOutput("blink_reload", {24'd0, led}, 32'hFF);
    stepCycles(15);
    checkOutput("blink_hold15", {24'd0, led}, 32'hFF);
    checkOutput("blink_hold15_step", {31'd0, step}, 32'd0);
    stepCycles(1);
    checkOutput("blink_toggle0", {24'd0, led}, 32'h00);
    checkOutput("blink_toggle0_step", {31'd0, step}, 32'd1);
    stepCycles(16);
    checkOutput("blink_toggle1", {24'd0, led}, 32'hFF);
    stepCycles(10);
    checkOutput("blink_cnt10_hold", {24'd0, led}, 32'hFF);
    applyStimulus(1'b1, 2'b11, 2'b00);
    stepCycles(1);
    checkOutput("speed_drop_led", {24'd0, led}, 32'h00);
    checkOutput("speed_drop_step", {31'd0, step}, 32'd1);

    // Freeze mid-period with the count held at 2.
    stepCycles(2);
    applyStimulus(1'b0, 2'b11, 2'b00);
    for (int i = 0; i < 20; i++) begin
      stepCycles(1);
      checkOutput("freeze_led", {24'd0, led}, 32'h00);
      checkOutput("freeze_step", {31'd0, step}, 32'd0);
    end
    applyStimulus(1'b1, 2'b11, 2'b00);
    stepCycles(1);
    checkOutput("resume_hold", {24'd0, led}, 32'h00);
    stepCycles(1);
    checkOutput("resume_led", {24'd0, led}, 32'hFF);
    checkOutput("resume_step", {31'd0, step}, 32'd1);

    // Mode change on the tick cycle takes priority over the step.
    applyStimulus(1'b1, 2'b00, 2'b00);
    stepCycles(1);
    checkOutput("rol_reload", {24'd0, led}, 32'h01);
    stepCycles(3);
    applyStimulus(1'b1, 2'b01, 2'b00);
    stepCycles(1);
    checkOutput("chg_on_tick_led", {24'd0, led}, 32'h80);
    checkOutput("chg_on_tick_step", {31'd0, step}, 32'd0);
    stepCycles(3);
    checkOutput("ror_hold", {24'd0, led}, 32'h80);
    stepCycles(1);
    checkOutput("ror_led", {24'd0, led}, 32'h40);
    checkOutput("ror_step", {31'd0, step}, 32'd1);

    // Asynchronous reset between clock edges.
    stepCycles(2);
    #3;
    rstN = 1'b0;
    #1;
    checkOutput("async_reset_led", {24'd0, led}, 32'h01);
    checkOutput("async_reset_step", {31'd0, step}, 32'd0);
    applyStimulus(1'b1, 2'b00, 2'b00);
    #2;
    rstN = 1'b1;
    stepCycles(3);
    checkOutput("post_reset_hold", {24'd0, led}, 32'h01);
    stepCycles(1);
    checkOutput("post_reset_led", {24'd0, led}, 32'h02);
    checkOutput("post_reset_step", {31'd0, step}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
Parametrised successor to the board LED chaser. It drives LED_NUM LEDs with one of four run-time-selectable patterns: rotate left, rotate right, ping-pong, or blink-all. The step rate is derived from CLK_FREQ and STEP_MS, with a run-time speed divider. It is instantiated in top on the BUFG'd system clock in place of the fixed chaser.

Parameters:
CLK_FREQ, 300_000_000, input clock frequency in Hz.
LED_NUM, 8, number of LEDs; legal range 2..32.
STEP_MS, 250, base step period in ms. STEP_CYCLES = CLK_FREQ/1000*STEP_MS, computed at elaboration; must be >= 1.

Ports:
CLK_i  input  1  system clock; all logic is rising-edge.
RSTn_i  input  1  reset, asynchronous and active-low.
ENABLE_i  input  1  1 = run, 0 = freeze the pattern and prescaler.
MODE_i  input  2  00 rotate-left, 01 rotate-right, 10 ping-pong, 11 blink-all.
SPEED_i  input  2  step period = STEP_CYCLES << SPEED_i (x1, x2, x4, x8).
LED_o  output  LED_NUM  LED drive, active-high, registered.
STEP_o  output  1  one-cycle pulse on each pattern step.

Behaviour:
- Reset (async assert, sync release) sets:
  - LED_o = 1 (bit0 lit), STEP_o = 0.
  - Prescaler = 0, mode_q = 00, ping-pong direction = up.
- Prescaler:
  - Width is $clog2((STEP_CYCLES<<3)+1).
  - Terminal T = (STEP_CYCLES << SPEED_i) - 1.
  - When ENABLE_i=1, the counter increments each cycle. When count >= T, it clears to 0 and a tick is generated.
  - The >= compare makes a SPEED_i decrease mid-period tick on the next cycle, never overrun.
- Tick effects: STEP_o=1 in the cycle after the terminal count, and LED_o updates in that same cycle. So there is one step every T+1 cycles.
- ENABLE_i=0: prescaler holds its value, LED_o holds, STEP_o=0. Resuming continues from the held count with no restart.
- Mode change:
  - MODE_i is registered into mode_q every cycle.
  - When MODE_i != mode_q, the next edge loads the new mode's initial pattern into LED_o, clears the prescaler, sets direction = up and forces STEP_o=0.
  - The reload happens even if ENABLE_i=0.
  - A mode change in the same cycle as a tick takes priority: the reload wins and no step occurs.
- Initial patterns:
  - 00: bit0 only.
  - 01: bit LED_NUM-1 only.
  - 10: bit0 only, direction up.
  - 11: all ones.
- Step rules:
  - 00: LED_o = {LED_o[LED_NUM-2:0], LED_o[LED_NUM-1]}. The MSB wraps to bit0.
  - 01: LED_o = {LED_o[0], LED_o[LED_NUM-1:1]}. Bit0 wraps to the MSB.
  - 10:
    - Direction up: shift left. When the new pattern has the MSB set, direction flips to down.
    - Direction down: shift right. When the new pattern has bit0 set, direction flips to up.
    - End LEDs are lit for exactly one step each (no doubled end step).
    - The period is 2*(LED_NUM-1) steps.
  - 11: LED_o = ~LED_o (all-on / all-off).
- Invariant: in modes 00/01/10, LED_o is always one-hot. If it is ever found zero (e.g. after an SEU), the next tick reloads the initial pattern.
- SPEED_i is not registered. It is used combinationally in the terminal compare.

Optional Feature:
LED_PWM_EN
- Defined:
  - Adds input DUTY_i[3:0] and a free-running 4-bit PWM counter (reset 0).
  - LED_o = pattern & {LED_NUM{pwm_cnt < DUTY_i}}, registered.
  - DUTY_i=0 gives all LEDs off. DUTY_i=15 gives 15/16 on.
  - STEP_o and the pattern state are unaffected by PWM gating.
- Undefined: the DUTY_i port does not exist, and LED_o equals the pattern register directly.

Test Plan:
All scenarios use CLK_FREQ=4000, STEP_MS=1 (STEP_CYCLES=4) and LED_NUM=8.
1. Reset, then MODE=00, SPEED=0, ENABLE=1 -> LED_o steps 01, 02, 04 … 80, 01, one step every 4 cycles. STEP_o pulses on each change.
2. MODE=10 -> sequence 01, 02 … 80, 40 … 02, 01, 02. Each of 01 and 80 appears once per 14-step period.
3. MODE=11, SPEED=2 -> LED_o toggles FF/00 every 16 cycles. Dropping SPEED to 0 when the count is 10 -> tick on the next cycle.
4. ENABLE=0 for 20 cycles mid-period -> LED_o frozen and STEP_o=0. On re-enable, the remaining period completes before the next step.
5. Switch MODE 00→01 in the same cycle the tick is due -> LED_o=80 next cycle, STEP_o=0, next step 4 cycles later (40). Assert RSTn_i low mid-step -> LED_o=01 immediately, without a clock edge.
6. With LED_PWM_EN defined, DUTY_i=4 -> each lit LED is high 4 of every 16 cycles. DUTY_i=0 -> LED_o=00 while STEP_o keeps pulsing.
